sensor_hub_aggregator: RTL and testbench
========================================

SENSOR_HUB_AGGREGATOR -- requirements
Module: sensor_hub_aggregator

Interface
REQ-001 Parameter NUM_CH, default 3, number of sensor channels (legal 1..8).
REQ-002 Parameter DATA_W, default 16, sample width per channel (legal 8, 16, 24, 32).
REQ-003 Parameter FLUSH_TIMEOUT, default 1024, idle cycles before a partial frame is forced (legal >= 1).
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 ch_enable  input  NUM_CH  per-channel enable.
REQ-007 ch_valid  input  NUM_CH  per-channel one-cycle sample strobe; no backpressure.
REQ-008 ch_data  input  NUM_CH*DATA_W  packed samples; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 tx_data  output  8  frame byte.
REQ-010 tx_valid  output  1  tx_data holds a valid byte.
REQ-011 tx_ready  input  1  downstream accepts the byte when it is high together with tx_valid.
REQ-012 frame_sent  output  1  one-cycle pulse after a frame's last byte is accepted.
REQ-013 overrun  output  NUM_CH  sticky per-channel overrun flags.
REQ-014 overrun_clr  input  1  synchronous clear of all overrun flags.

Function
REQ-015 On ch_valid[i] && ch_enable[i], the design SHALL latch ch_data[i] into hold[i] and set pending[i].
REQ-016 A capture while pending[i] is already set SHALL overwrite hold[i] and set overrun[i]; the newest sample always wins.
REQ-017 ch_valid[i] with ch_enable[i] low SHALL be ignored; deasserting ch_enable[i] SHALL clear pending[i] next cycle.
REQ-018 FSM states: IDLE, SYNC, MASK, DATA, CSUM; a frame starts only from IDLE.
REQ-019 Frame start (IDLE->SYNC) SHALL occur on the edge where (pending & ch_enable) != 0 and either (pending & ch_enable) == ch_enable or flush_cnt == FLUSH_TIMEOUT.
REQ-020 flush_cnt SHALL increment each IDLE cycle with nonzero enabled pending, saturate at FLUSH_TIMEOUT, and clear at frame start or when no enabled channel is pending.
REQ-021 At frame start, frame_mask <= pending & ch_enable; the matching hold registers are snapshotted and those pending bits cleared.
REQ-022 A capture on a channel in the same cycle as frame start SHALL set pending again without setting overrun; the snapshot takes the old value.
REQ-023 Byte order: 0xA5 (SYNC), frame_mask zero-extended to 8 bits (MASK), then each set channel in ascending index, DATA_W/8 bytes MSB first (DATA), then the checksum if enabled (CSUM).
REQ-024 Each byte SHALL be presented with tx_valid high and held stable until tx_valid && tx_ready; the FSM advances only on that handshake, with no idle bubbles.
REQ-025 tx_valid with 0xA5 SHALL be asserted in the cycle after the frame-start edge.
REQ-026 After the last byte handshake, the FSM returns to IDLE and frame_sent pulses for exactly one cycle on the following cycle.
REQ-027 A new frame SHALL NOT start in the same cycle that frame_sent is high; earliest start is the next edge.
REQ-028 overrun_clr and a new overrun event on the same edge: the set wins for that channel.
REQ-029 Captures continue during frame transmission; only pending and hold are affected, never the in-flight snapshot.

Reset
REQ-030 While rst is high: FSM in IDLE; pending, hold, snapshot, frame_mask, flush_cnt, overrun = 0; tx_valid = 0; tx_data = 0x00; frame_sent = 0.
REQ-031 Assertion of rst mid-frame SHALL abort the frame immediately; no partial byte is completed after release.

Configuration
REQ-032 Macro SENSOR_HUB_CSUM_EN defined: the CSUM state emits one byte equal to the XOR of the MASK byte and all DATA bytes.
REQ-033 SENSOR_HUB_CSUM_EN undefined: the CSUM state and the checksum logic are absent; the frame ends after the last DATA byte.

Verification (NUM_CH=3, DATA_W=16, tx_ready=1 unless stated)
REQ-034 ch_enable=3'b111; ch0=0x1234, ch1=0xABCD, ch2=0x0F0F strobed -> bytes A5 07 12 34 AB CD 0F 0F 47 (CSUM_EN), then one frame_sent pulse.
REQ-035 Only ch1=0x00FF strobed, ch_enable=3'b111, FLUSH_TIMEOUT=100 -> no output for 100 idle cycles, then A5 02 00 FF FD.
REQ-036 ch0 strobed twice (0x1111 then 0x2222) before frame start -> overrun=3'b001 and frame carries 22 22; overrun_clr -> overrun=0.
REQ-037 tx_ready held low 5 cycles on the MASK byte -> tx_data stays 0x07 with tx_valid high; the sequence resumes intact.
REQ-038 rst pulsed during the DATA state -> tx_valid=0 next cycle, all outputs at reset values; the next complete sample set yields a full, correct frame.

Source files
------------

// File: rtl/sensor_hub_aggregator.sv
// Multi-channel sensor sample aggregator that serialises latched samples into byte frames.
// Define SENSOR_HUB_CSUM_EN to append an XOR checksum byte to every frame.
module sensor_hub_aggregator #(
  parameter int NUM_CH        = 3,
  parameter int DATA_W        = 16,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     frame_sent,
  output logic [NUM_CH-1:0]        overrun,
  input  logic                     overrun_clr
);

  localparam int BYTES = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    MASK,
`ifdef SENSOR_HUB_CSUM_EN
    DATA,
    CSUM
`else
    DATA
`endif
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] frame_mask;
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [CNT_W-1:0]  flush_cnt;
  logic [CH_W-1:0]   ch_idx;
  logic [BI_W-1:0]   byte_idx;
`ifdef SENSOR_HUB_CSUM_EN
  logic [7:0]        csum;
`endif

  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] capture;
  logic              hs;
  logic              flush_due;
  logic              start;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              next_found;

  assign active    = pending & ch_enable;
  assign capture   = ch_valid & ch_enable;
  assign hs        = tx_valid && tx_ready;
  assign flush_due = (flush_cnt == CNT_W'(FLUSH_TIMEOUT));
  // The frame_sent cycle is deliberately excluded so back-to-back frames keep a one-cycle gap.
  assign start     = (state == IDLE) && !frame_sent && (active != '0) &&
                     ((active == ch_enable) || flush_due);

  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (frame_mask[j]) first_ch = CH_W'(j);
      if (frame_mask[j] && (j > int'(ch_idx))) begin
        next_ch    = CH_W'(j);
        next_found = 1'b1;
      end
    end
  end

  function automatic logic [7:0] data_byte(input logic [DATA_W-1:0] word,
                                           input logic [BI_W-1:0]   idx);
    logic [DATA_W-1:0] shifted;
    shifted = word >> (8 * (BYTES - 1 - int'(idx)));
    return shifted[7:0];
  endfunction

  // A capture landing on the frame-start edge re-arms pending without counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_enable[i]) begin
          pending[i] <= 1'b0;
        end else if (capture[i]) begin
          hold[i]    <= ch_data[i*DATA_W +: DATA_W];
          pending[i] <= 1'b1;
        end else if (start && active[i]) begin
          pending[i] <= 1'b0;
        end
        overrun[i] <= (overrun[i] && !overrun_clr) || (capture[i] && pending[i] && !start);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (start || (active == '0)) begin
      flush_cnt <= '0;
    end else if ((state == IDLE) && !flush_due) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      frame_sent <= 1'b0;
      frame_mask <= '0;
      ch_idx     <= '0;
      byte_idx   <= '0;
`ifdef SENSOR_HUB_CSUM_EN
      csum       <= 8'h00;
`endif
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      frame_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SYNC;
            tx_valid   <= 1'b1;
            tx_data    <= SYNC_BYTE;
            frame_mask <= active;
`ifdef SENSOR_HUB_CSUM_EN
            csum       <= 8'h00;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
              if (active[i]) snap[i] <= hold[i];
            end
          end
        end
        SYNC: begin
          if (hs) begin
            state   <= MASK;
            tx_data <= 8'(frame_mask);
          end
        end
        MASK: begin
          if (hs) begin
            state    <= DATA;
            ch_idx   <= first_ch;
            byte_idx <= '0;
            tx_data  <= data_byte(snap[first_ch], '0);
`ifdef SENSOR_HUB_CSUM_EN
            csum     <= csum ^ tx_data;
`endif
          end
        end
        DATA: begin
          if (hs) begin
`ifdef SENSOR_HUB_CSUM_EN
            csum <= csum ^ tx_data;
`endif
            if (byte_idx != BI_W'(BYTES - 1)) begin
              byte_idx <= byte_idx + 1'b1;
              tx_data  <= data_byte(snap[ch_idx], byte_idx + 1'b1);
            end else if (next_found) begin
              ch_idx   <= next_ch;
              byte_idx <= '0;
              tx_data  <= data_byte(snap[next_ch], '0);
            end else begin
`ifdef SENSOR_HUB_CSUM_EN
              state   <= CSUM;
              tx_data <= csum ^ tx_data;
`else
              state      <= IDLE;
              tx_valid   <= 1'b0;
              tx_data    <= 8'h00;
              frame_sent <= 1'b1;
`endif
            end
          end
        end
`ifdef SENSOR_HUB_CSUM_EN
        CSUM: begin
          if (hs) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            frame_sent <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_hub_aggregator.sv
// Bench for sensor_hub_aggregator: queue-based frame model checked every cycle plus directed literal frames.
module tb_sensor_hub_aggregator;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int TO     = 100;

  typedef byte unsigned bq_t[$];

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     frame_sent;
  logic [NUM_CH-1:0]        overrun;
  logic                     overrun_clr;

  int checks = 0;
  int errors = 0;
  bq_t got;
  int sent_count = 0;

  always #5 clk = ~clk;

  sensor_hub_aggregator #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .FLUSH_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_enable(ch_enable),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .frame_sent(frame_sent),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Model: pending/hold per channel and a queue holding the bytes of the frame in flight.
  logic [NUM_CH-1:0] m_pending, m_overrun, m_active, m_set;
  logic [DATA_W-1:0] m_hold [NUM_CH];
  int  m_flush;
  bq_t mq;
  bit  m_sent, m_idle, m_consumed, m_last, m_start;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = '0;
      m_overrun = '0;
      m_flush   = 0;
      m_sent    = 1'b0;
      mq.delete();
      for (int i = 0; i < NUM_CH; i++) m_hold[i] = '0;
    end else begin
      m_active   = m_pending & ch_enable;
      m_idle     = (mq.size() == 0);
      m_consumed = !m_idle && tx_ready;
      m_last     = m_consumed && (mq.size() == 1);
      m_start    = m_idle && !m_sent && (m_active != '0) &&
                   ((m_active == ch_enable) || (m_flush == TO));
      if (m_consumed) void'(mq.pop_front());
      if (m_start) begin
        mq.push_back(8'hA5);
        mq.push_back(8'(m_active));
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_active[c]) begin
            mq.push_back(m_hold[c][15:8]);
            mq.push_back(m_hold[c][7:0]);
          end
        end
`ifdef SENSOR_HUB_CSUM_EN
        begin
          byte unsigned s;
          s = 8'h00;
          for (int k = 1; k < mq.size(); k++) s ^= mq[k];
          mq.push_back(s);
        end
`endif
      end
      m_sent = m_last;
      if ((m_active == '0) || m_start) m_flush = 0;
      else if (m_idle && (m_flush < TO)) m_flush++;
      m_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_enable[i]) begin
          m_pending[i] = 1'b0;
        end else if (ch_valid[i]) begin
          if (m_pending[i] && !m_start) m_set[i] = 1'b1;
          m_hold[i]    = ch_data[i*DATA_W +: DATA_W];
          m_pending[i] = 1'b1;
        end else if (m_start && m_active[i]) begin
          m_pending[i] = 1'b0;
        end
      end
      m_overrun = (overrun_clr ? '0 : m_overrun) | m_set;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checkOutput("model_tx_valid", 32'(tx_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) checkOutput("model_tx_data", 32'(tx_data), 32'(mq[0]));
      checkOutput("model_frame_sent", 32'(frame_sent), 32'(m_sent));
      checkOutput("model_overrun", 32'(overrun), 32'(m_overrun));
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && tx_valid && tx_ready) got.push_back(tx_data);
    if (!rst && frame_sent) sent_count++;
  end

  task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2);
    @(negedge clk);
    ch_valid = valid;
    ch_data  = {d2, d1, d0};
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic waitSent(input string name, input int more, input int budget);
    int target;
    int n;
    target = sent_count + more;
    n = 0;
    while (sent_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_frames_sent"}, 32'(sent_count), 32'(target));
  endtask

  task automatic expectFrame(input string name, input bq_t exp);
    bq_t e;
    e = exp;
`ifndef SENSOR_HUB_CSUM_EN
    void'(e.pop_back());
`endif
    checkOutput({name, "_len_ok"}, 32'(got.size() >= e.size()), 32'd1);
    for (int k = 0; k < e.size(); k++) begin
      if (got.size() > 0) begin
        checkOutput($sformatf("%s_byte%0d", name, k), 32'(got[0]), 32'(e[k]));
        void'(got.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bq_t f;
    int  n;
    rst = 1'b1; ch_enable = '0; ch_valid = '0; ch_data = '0; tx_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h00);
    checkOutput("reset_frame_sent", 32'(frame_sent), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    ch_enable = 3'b111;

    $display("[TB] full sample set");
    applyStimulus(3'b111, 16'h1234, 16'hABCD, 16'h0F0F);
    waitSent("full", 1, 60);
    f = '{8'hA5, 8'h07, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h47};
    expectFrame("full", f);
    checkOutput("full_single_pulse", 32'(sent_count), 32'd1);

    $display("[TB] flush timeout");
    @(negedge clk);
    ch_valid = 3'b010;
    ch_data  = {16'h0, 16'h00FF, 16'h0};
    n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      ch_valid = '0;
      n++;
    end
    checkOutput("flush_latency", 32'(n), 32'(TO + 2));
    waitSent("flush", 1, 60);
    f = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFD};
    expectFrame("flush", f);

    $display("[TB] overrun");
    @(negedge clk); ch_valid = 3'b001; ch_data = {16'h0, 16'h0, 16'h1111};
    @(negedge clk); ch_valid = 3'b001; ch_data = {16'h0, 16'h0, 16'h2222};
    @(negedge clk); ch_valid = '0;
    checkOutput("overrun_set", 32'(overrun), 32'b001);
    waitSent("overrun", 1, 250);
    f = '{8'hA5, 8'h01, 8'h22, 8'h22, 8'h01};
    expectFrame("overrun", f);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    checkOutput("overrun_clr", 32'(overrun), 32'd0);

    $display("[TB] clear and set on same edge");
    @(negedge clk); ch_valid = 3'b001; ch_data = {16'h0, 16'h0, 16'h3333};
    @(negedge clk); ch_valid = 3'b001; ch_data = {16'h0, 16'h0, 16'h4444}; overrun_clr = 1'b1;
    @(negedge clk); ch_valid = '0; overrun_clr = 1'b0;
    checkOutput("set_beats_clr", 32'(overrun), 32'b001);
    waitSent("set_beats_clr", 1, 250);
    f = '{8'hA5, 8'h01, 8'h44, 8'h44, 8'h01};
    expectFrame("set_beats_clr", f);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;

    $display("[TB] backpressure on mask byte");
    tx_ready = 1'b0;
    applyStimulus(3'b111, 16'h1234, 16'hABCD, 16'h0F0F);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_sync_byte", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall_valid%0d", k), 32'(tx_valid), 32'd1);
      checkOutput($sformatf("stall_mask%0d", k), 32'(tx_data), 32'h07);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    waitSent("stall", 1, 60);
    f = '{8'hA5, 8'h07, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h47};
    expectFrame("stall", f);

    $display("[TB] enable handling");
    ch_enable = 3'b101;
    applyStimulus(3'b010, 16'h0, 16'h5555, 16'h0);
    repeat (5) @(negedge clk);
    checkOutput("disabled_ignored", 32'(tx_valid), 32'd0);
    ch_enable = 3'b111;
    applyStimulus(3'b010, 16'h0, 16'h6666, 16'h0);
    ch_enable = 3'b101;
    repeat (120) @(negedge clk);
    checkOutput("disable_clears_pending", 32'(got.size()), 32'd0);
    applyStimulus(3'b101, 16'hBEEF, 16'h0, 16'hCAFE);
    waitSent("partial_mask", 1, 60);
    f = '{8'hA5, 8'h05, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h60};
    expectFrame("partial_mask", f);
    ch_enable = 3'b111;

    $display("[TB] capture on start edge and during frame");
    applyStimulus(3'b111, 16'h0102, 16'h0304, 16'h0506);
    ch_valid = 3'b001; ch_data = {16'h0, 16'h0, 16'h7777};
    @(negedge clk); ch_valid = '0;
    @(negedge clk); ch_valid = 3'b110; ch_data = {16'h9999, 16'h8888, 16'h0};
    @(negedge clk); ch_valid = '0;
    waitSent("back_to_back", 2, 100);
    f = '{8'hA5, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    expectFrame("snapshot_old", f);
    f = '{8'hA5, 8'h07, 8'h77, 8'h77, 8'h88, 8'h88, 8'h99, 8'h99, 8'h07};
    expectFrame("second_frame", f);
    checkOutput("start_edge_no_overrun", 32'(overrun), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(3'b111, 16'h1234, 16'hABCD, 16'h0F0F);
    n = 0;
    while (got.size() < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    checkOutput("abort_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort_tx_data", 32'(tx_data), 32'h00);
    checkOutput("abort_frame_sent", 32'(frame_sent), 32'd0);
    checkOutput("abort_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    applyStimulus(3'b111, 16'hDEAD, 16'hBEEF, 16'h0001);
    waitSent("after_reset", 1, 60);
    f = '{8'hA5, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01, 8'h24};
    expectFrame("after_reset", f);
    checkOutput("no_stray_bytes", 32'(got.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
